// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage; runs one bus transaction per load/store and
// aligns/extends load data, passing non-memory results straight to writeback.
package lsu_pkg;
  localparam logic [5:0] I_ADD = 6'd0;
  localparam logic [5:0] I_LB  = 6'd1;
  localparam logic [5:0] I_LH  = 6'd2;
  localparam logic [5:0] I_LW  = 6'd3;
  localparam logic [5:0] I_LBU = 6'd4;
  localparam logic [5:0] I_LHU = 6'd5;
  localparam logic [5:0] I_SB  = 6'd6;
  localparam logic [5:0] I_SH  = 6'd7;
  localparam logic [5:0] I_SW  = 6'd8;
endpackage

module lsu_mem_stage import lsu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       instr_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] rs2,
  input  logic [4:0]       rd_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t           r_state;
  logic [5:0]       r_instr;
  logic [1:0]       r_ofs;
  logic [4:0]       r_rd;
  logic             r_st;
  logic [WIDTH-1:0] r_rdata;
  logic [CW-1:0]    r_cnt;
  logic w_ld, w_st, w_byte, w_half, w_mis, w_done, w_timeout;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wd, w_bs, w_hs, w_ld_data;
  assign w_ld      = instr_in inside {I_LB, I_LH, I_LW, I_LBU, I_LHU};
  assign w_st      = instr_in inside {I_SB, I_SH, I_SW};
  assign w_byte    = instr_in inside {I_LB, I_LBU, I_SB};
  assign w_half    = instr_in inside {I_LH, I_LHU, I_SH};
  assign w_mis     = w_half ? alu_out[0] : !w_byte && |alu_out[1:0];
  assign w_be      = w_byte ? 4'b0001 << alu_out[1:0] : w_half ? 4'b0011 << alu_out[1:0] : 4'b1111;
  assign w_wd      = w_byte ? {4{rs2[7:0]}} : w_half ? {2{rs2[15:0]}} : rs2;
  assign w_bs      = r_rdata >> {r_ofs, 3'b000};
  assign w_hs      = r_rdata >> {r_ofs[1], 4'b0000};
  assign w_ld_data = r_instr == I_LB  ? {{24{w_bs[7]}}, w_bs[7:0]} :
                     r_instr == I_LBU ? {24'b0, w_bs[7:0]} :
                     r_instr == I_LH  ? {{16{w_hs[15]}}, w_hs[15:0]} :
                     r_instr == I_LHU ? {16'b0, w_hs[15:0]} : r_rdata;
  // A response in the grant cycle completes the request without visiting WAIT.
  assign w_done    = mem_rvalid && (r_state == WAIT || mem_gnt);
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
      r_instr   <= '0;
      r_ofs     <= '0;
      r_rd      <= '0;
      r_st      <= 1'b0;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        IDLE:
          if (in_valid) begin
            if (!(w_ld || w_st)) begin
              wb_valid <= 1'b1;
              wb_data  <= alu_out;
              wb_rd    <= rd_in;
            end else if (w_mis) err <= 1'b1;
            else begin
              r_state   <= REQ;
              in_ready  <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= w_st;
              mem_addr  <= {alu_out[WIDTH-1:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wd;
              r_instr   <= instr_in;
              r_ofs     <= alu_out[1:0];
              r_rd      <= w_st ? 5'd0 : rd_in;
              r_st      <= w_st;
              r_cnt     <= '0;
            end
          end
        REQ, WAIT:
          if (w_done) begin
            r_state <= RESP;
            r_rdata <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (w_timeout) begin
            r_state  <= IDLE;
            err      <= 1'b1;
            in_ready <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == REQ && mem_gnt) begin
              r_state <= WAIT;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        RESP: begin
          r_state  <= IDLE;
          in_ready <= 1'b1;
          wb_valid <= 1'b1;
          wb_rd    <= r_rd;
          wb_data  <= r_st ? '0 : w_ld_data;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized ops against a transaction-level model that predicts the
// cycle and content of every writeback/err pulse plus the request and ready windows.
module tb_lsu_mem_stage;
  import lsu_pkg::*;
  logic        clk = 0, rst = 0, in_valid = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [5:0]  instr_in = 0;
  logic [31:0] alu_out = 0, rs2 = 0, mem_rdata = 0;
  logic [4:0]  rd_in = 0;
  logic        in_ready, mem_req, mem_we, wb_valid, err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;
  lsu_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
    .alu_out(alu_out), .rs2(rs2), .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; bit is_err; logic [4:0] rd; logic [31:0] data; bit chk_data;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0, n_err = 0;
  int req_lo = 0, req_hi = -1, busy_lo = 0, busy_hi = -1;
  bit mon_en = 0;
  logic [31:0] exp_addr, exp_wd, last_wb_data, last_wd, last_addr;
  logic [3:0]  exp_be, last_be;
  logic [4:0]  last_wb_rd;
  logic        exp_we;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction
  function automatic int size_of(input logic [5:0] ins);
    if (ins == I_LB || ins == I_LBU || ins == I_SB) return 1;
    if (ins == I_LH || ins == I_LHU || ins == I_SH) return 2;
    if (ins == I_LW || ins == I_SW) return 4;
    return 0;
  endfunction
  function automatic logic [31:0] ld_val(input logic [5:0] ins, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (size_of(ins) == 1) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (ins == I_LB && v >= 128) v = v - 256;
    end else if (size_of(ins) == 2) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (ins == I_LH && v >= 32768) v = v - 65536;
    end else v = w;
    return v;
  endfunction
  always @(negedge clk) if (mon_en) begin
    bit er, ebusy;
    er = cyc >= req_lo && cyc <= req_hi;
    ebusy = cyc >= busy_lo && cyc <= busy_hi;
    if (wb_valid && err) chk("wb_and_err", 32'd1, 32'd0);
    if (wb_valid || err) begin
      if (err) n_err++;
      if (wb_valid) begin
        last_wb_data = wb_data;
        last_wb_rd = wb_rd;
      end
      if (q.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_is_err", err, e.is_err);
        if (!e.is_err) chk("wb_rd", wb_rd, e.rd);
        if (!e.is_err && e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      chk("pulse_missing", 32'd0, 32'd1);
      void'(q.pop_front());
    end
    chk("mem_req", mem_req, er);
    chk("in_ready", in_ready, !ebusy);
    if (mem_req && er) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_be", mem_be, exp_be);
      chk("mem_we", mem_we, exp_we);
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
      last_be = mem_be;
      last_wd = mem_wdata;
      last_addr = mem_addr;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Issues one instruction; g = REQ cycles before grant, r = cycles from grant to response.
  task automatic op(input logic [5:0] ins, input logic [31:0] a, input logic [31:0] d2,
                    input logic [4:0] rd, input int g, input int r, input logic [31:0] rdat);
    int k, sz, n, done;
    bit mis, st;
    exp_t e;
    k = cyc;
    sz = size_of(ins);
    st = ins == I_SB || ins == I_SH || ins == I_SW;
    mis = (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
    in_valid = 1; instr_in = ins; alu_out = a; rs2 = d2; rd_in = rd;
    n = g + 1 + r;
    done = k + 1;
    if (sz == 0) e = '{k + 1, 0, rd, a, 1};
    else if (mis) e = '{k + 1, 1, 0, 0, 0};
    else begin
      done = n <= 16 ? k + g + r + 3 : k + 17;
      req_lo = k + 1;
      req_hi = g + 1 <= 16 ? k + g + 1 : k + 16;
      busy_lo = k + 1;
      busy_hi = done - 1;
      exp_addr = a - a % 4;
      exp_be = sz == 1 ? 4'(1 << (a % 4)) : sz == 2 ? 4'(3 << (a % 4)) : 4'd15;
      exp_wd = sz == 1 ? d2[7:0] * 32'h01010101 : sz == 2 ? d2[15:0] * 32'h00010001 : d2;
      exp_we = st;
      e = '{done, n > 16, st ? 5'd0 : rd, ld_val(ins, a, rdat), !st};
    end
    q.push_back(e);
    step();
    in_valid = 0;
    while (cyc < done) begin
      mem_gnt = g + 1 <= 16 && cyc == k + g + 1;
      mem_rvalid = n <= 16 && cyc == k + n;
      mem_rdata = rdat;
      step();
    end
    mem_gnt = 0;
    mem_rvalid = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1); chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_err", err, 0);
    chk("rst_mem_be", mem_be, 0);     chk("rst_wb_data", wb_data, 0);
    rst = 1;
    step();
    mon_en = 1;
    op(I_ADD, 32'h1234, 0, 5'd3, 0, 0, 0);
    step();
    chk("t1_wb_data", last_wb_data, 32'h1234);
    op(I_LB, 32'h103, 0, 5'd7, 0, 0, 32'h80FF_0000);
    step();
    chk("t2_addr", last_addr, 32'h100); chk("t2_be", last_be, 4'b1000);
    chk("t2_lb", last_wb_data, 32'hFFFF_FF80);
    op(I_LBU, 32'h103, 0, 5'd7, 1, 2, 32'h80FF_0000);
    step();
    chk("t2_lbu", last_wb_data, 32'h80);
    op(I_SH, 32'h102, 32'hABCD_1234, 5'd9, 0, 1, 0);
    step();
    chk("t3_be", last_be, 4'b1100); chk("t3_wdata", last_wd, 32'h1234_1234);
    chk("t3_wb_rd", last_wb_rd, 0);
    n0 = n_err;
    op(I_LW, 32'h101, 0, 5'd4, 0, 0, 0);
    step();
    chk("t4_err_count", n_err - n0, 1);
    n0 = n_err;
    op(I_LW, 32'h40, 0, 5'd4, 40, 0, 0);
    chk("t5_ready_after", in_ready, 1);
    mem_rvalid = 1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 0;
    step();
    chk("t5_err_count", n_err - n0, 1);
    op(I_LW, 32'h3C, 0, 5'd6, 15, 0, 32'h0BAD_F00D);
    step();
    chk("t5_edge_lw", last_wb_data, 32'h0BAD_F00D);
    for (int i = 0; i < 200; i++) begin
      logic [5:0] ins;
      int g;
      ins = 6'($urandom_range(0, 12));
      g = $urandom_range(0, 9) == 0 ? $urandom_range(12, 20) : $urandom_range(0, 3);
      op(ins, $urandom & 32'hFFFF, $urandom, 5'($urandom_range(1, 31)), g,
         $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
    repeat (3) step();
    mon_en = 0;
    in_valid = 1; instr_in = I_LW; alu_out = 32'h200; rd_in = 5'd2;
    step();
    in_valid = 0; mem_gnt = 1;
    step();
    mem_gnt = 0;
    step();
    rst = 0;
    #1;
    chk("t6_in_ready", in_ready, 1); chk("t6_mem_req", mem_req, 0);
    chk("t6_mem_we", mem_we, 0);     chk("t6_wb_valid", wb_valid, 0);
    chk("t6_err", err, 0);           chk("t6_mem_be", mem_be, 0);
    chk("t6_mem_addr", mem_addr, 0); chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_wb_rd", wb_rd, 0);       chk("t6_wb_data", wb_data, 0);
    mem_rvalid = 1;
    step();
    mem_rvalid = 0;
    step();
    rst = 1;
    q.delete();
    req_hi = -1;
    busy_hi = -1;
    step();
    mon_en = 1;
    op(I_ADD, 32'h55AA, 0, 5'd12, 0, 0, 0);
    step();
    chk("t6_add_after", last_wb_data, 32'h55AA);
    repeat (3) step();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
